// File: rtl/latch_bank_writer.sv
// latch_bank_writer
//   Write-side sequencer for a bank of level-sensitive D latches. It accepts
//   one write at a time over valid/ready. It then drives the shared data bus
//   and a single enable through a setup, strobe and hold sequence, so that
//   the data is stable for the whole time an enable is high.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active low
//   in_valid  write request valid
//   in_ready  writer can accept a request (IDLE and out of reset)
//   in_addr   target latch index
//   in_data   value to latch
//   lat_d     shared data bus to every latch D input
//   lat_en    per-latch enable, at most one bit high
//   busy      sequence in progress (state != IDLE)
//   err       one-cycle pulse when an out-of-range address is accepted
//
// Every output comes straight from a flop. Outputs are computed from the
// next state, so an enable never sees a combinational glitch.
module latch_bank_writer #(
    parameter int DATA_W     = 8,
    parameter int N_LATCH    = 4,
    parameter int ADDR_W     = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [DATA_W-1:0]  in_data,
    output logic [DATA_W-1:0]  lat_d,
    output logic [N_LATCH-1:0] lat_en,
    output logic               busy,
    output logic               err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]         state, nxt;
    logic [3:0]         cnt, nxt_cnt;
    logic [ADDR_W-1:0]  addr_q, wr_addr;
    logic [N_LATCH-1:0] en_nxt;
    logic               accept, addr_ok;

    assign accept  = in_valid && in_ready;
    assign addr_ok = int'(in_addr) < N_LATCH;
    // On the accept edge the address register is not loaded yet, so the
    // enable decode has to take the address from the input.
    assign wr_addr = (state == IDLE) ? in_addr : addr_q;

    // A single shared down-counter. Each phase loads (count - 1) on entry
    // and leaves the phase when the counter reaches zero. Zero-length phases
    // are skipped at the point where their predecessor ends.
    always_comb begin
        nxt     = state;
        nxt_cnt = cnt;
        case (state)
            IDLE: begin
                if (accept && addr_ok) begin
                    if (SETUP_CYC > 0) begin
                        nxt     = SETUP;
                        nxt_cnt = 4'(SETUP_CYC - 1);
                    end else begin
                        nxt     = STROBE;
                        nxt_cnt = 4'(STROBE_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    nxt     = STROBE;
                    nxt_cnt = 4'(STROBE_CYC - 1);
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    if (HOLD_CYC > 0) begin
                        nxt     = HOLD;
                        nxt_cnt = 4'(HOLD_CYC - 1);
                    end else begin
                        nxt     = IDLE;
                        nxt_cnt = 4'd0;
                    end
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
            default: begin
                if (cnt == 4'd0) begin
                    nxt     = IDLE;
                    nxt_cnt = 4'd0;
                end else begin
                    nxt_cnt = cnt - 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        en_nxt = '0;
        for (int i = 0; i < N_LATCH; i++)
            en_nxt[i] = (nxt == STROBE) && (wr_addr == ADDR_W'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            lat_d    <= '0;
            lat_en   <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= nxt_cnt;
            if (accept && addr_ok) begin
                addr_q <= in_addr;
                lat_d  <= in_data;
            end
            lat_en   <= en_nxt;
            busy     <= (nxt != IDLE);
            err      <= accept && !addr_ok;
            in_ready <= (nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_latch_bank_writer.sv
// Testbench for latch_bank_writer. It uses three instances:
//   u0 defaults (setup 1, strobe 2, hold 1, 4 latches)
//   u1 zero setup/hold, strobe 1
//   u2 three latches, so address 3 is out of range
// A transaction-level model tracks cycles since accept for each instance.
// The model is checked against the DUT every cycle. Directed checks with
// literal values pin the model.
module tb_latch_bank_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] vld;
    logic [1:0] ad [3];
    logic [7:0] dt [3];

    logic [2:0] rdy, bsy, er;
    logic [7:0] ld [3];
    logic [3:0] en0, en1;
    logic [2:0] en2;
    logic [3:0] den [3];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    latch_bank_writer u0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_addr(ad[0]), .in_data(dt[0]), .lat_d(ld[0]), .lat_en(en0),
        .busy(bsy[0]), .err(er[0]));

    latch_bank_writer #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_addr(ad[1]), .in_data(dt[1]), .lat_d(ld[1]), .lat_en(en1),
        .busy(bsy[1]), .err(er[1]));

    latch_bank_writer #(.N_LATCH(3)) u2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_addr(ad[2]), .in_data(dt[2]), .lat_d(ld[2]), .lat_en(en2),
        .busy(bsy[2]), .err(er[2]));

    assign den[0] = en0;
    assign den[1] = en1;
    assign den[2] = {1'b0, en2};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // Model: a write occupies S+P+H cycles after its accept edge. The
    // enable is high for k in [S, S+P), where k counts edges after accept.
    int   ms [3] = '{1, 0, 1};
    int   mp [3] = '{2, 1, 2};
    int   mh [3] = '{1, 0, 1};
    int   mn [3] = '{4, 4, 3};
    int   k    [3];
    bit   act  [3];
    int   m_a  [3];
    logic [7:0] m_d [3];
    bit   m_rdy[3], m_err[3], m_busy[3];
    logic [7:0] prev_d0;
    logic [3:0] prev_en0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            k[i] = 0; act[i] = 0; m_a[i] = 0; m_d[i] = 8'h00;
            m_rdy[i] = 0; m_err[i] = 0; m_busy[i] = 0;
        end
        prev_d0  = 8'h00;
        prev_en0 = 4'h0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst) begin
                    act[i] = 0; m_d[i] = 8'h00; m_err[i] = 0; m_rdy[i] = 0; m_busy[i] = 0;
                end else begin
                    m_err[i] = 0;
                    if (m_rdy[i] && vld[i]) begin
                        if (int'(ad[i]) < mn[i]) begin
                            act[i] = 1; k[i] = 0; m_a[i] = int'(ad[i]); m_d[i] = dt[i];
                        end else begin
                            m_err[i] = 1;
                        end
                    end else if (act[i]) begin
                        k[i]++;
                    end
                    if (act[i] && k[i] >= ms[i] + mp[i] + mh[i]) act[i] = 0;
                    m_busy[i] = act[i];
                    m_rdy[i]  = !act[i];
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                logic [3:0] e;
                e = (act[i] && k[i] >= ms[i] && k[i] < ms[i] + mp[i]) ? 4'(1 << m_a[i]) : 4'h0;
                chk($sformatf("u%0d lat_en", i), 32'(den[i]), 32'(e));
                chk($sformatf("u%0d lat_d", i), 32'(ld[i]), 32'(m_d[i]));
                chk($sformatf("u%0d in_ready", i), 32'(rdy[i]), 32'(m_rdy[i]));
                chk($sformatf("u%0d busy", i), 32'(bsy[i]), 32'(m_busy[i]));
                chk($sformatf("u%0d err", i), 32'(er[i]), 32'(m_err[i]));
            end
            // At most one enable. Data is frozen while an enable stays high.
            chk("u0 enable onehot", 32'($countones(en0) <= 1), 32'd1);
            if (prev_en0 != 4'h0 && en0 != 4'h0)
                chk("u0 lat_d stable under enable", 32'(ld[0]), 32'(prev_d0));
            prev_d0  = ld[0];
            prev_en0 = en0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        vld = 3'b111;
        for (int i = 0; i < 3; i++) begin ad[i] = 2'd2; dt[i] = 8'h55; end

        // Requests are ignored while reset is held.
        @(posedge clk); @(posedge clk); @(posedge clk);
        tick();
        chk("reset lat_en", 32'(en0), 32'h0);
        chk("reset lat_d", 32'(ld[0]), 32'h00);
        chk("reset in_ready", 32'(rdy[0]), 32'h0);
        rst = 1'b1;
        vld = 3'b000;
        tick();
        chk("ready after release", 32'(rdy[0]), 32'h1);

        // Single write with default timing, accepted at edge T.
        vld[0] = 1'b1; ad[0] = 2'd2; dt[0] = 8'hA5;
        tick();
        vld[0] = 1'b0;
        chk("T lat_d", 32'(ld[0]), 32'hA5);
        chk("T lat_en", 32'(en0), 32'h0);
        tick();
        chk("T+1 lat_en", 32'(en0), 32'h4);
        tick();
        chk("T+2 lat_en", 32'(en0), 32'h4);
        tick();
        chk("T+3 lat_en", 32'(en0), 32'h0);
        chk("T+3 in_ready", 32'(rdy[0]), 32'h0);
        tick();
        chk("T+4 in_ready", 32'(rdy[0]), 32'h1);
        chk("T+4 lat_d kept", 32'(ld[0]), 32'hA5);

        // Back-to-back: with occupancy 4, in_ready returns after edge T+4.
        // The next accept is therefore at edge T+5.
        vld[0] = 1'b1; ad[0] = 2'd0; dt[0] = 8'h11;
        tick();
        chk("b2b first lat_d", 32'(ld[0]), 32'h11);
        ad[0] = 2'd3; dt[0] = 8'h22;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ld[0] == 8'h22) begin n = i; break; end
        end
        vld[0] = 1'b0;
        chk("b2b second accept spacing", 32'(n), 32'd5);
        repeat (5) tick();

        // Zero-length setup and hold.
        vld[1] = 1'b1; ad[1] = 2'd1; dt[1] = 8'h3C;
        tick();
        vld[1] = 1'b0;
        chk("zero T lat_en", 32'(en1), 32'h2);
        chk("zero T in_ready", 32'(rdy[1]), 32'h0);
        tick();
        chk("zero T+1 lat_en", 32'(en1), 32'h0);
        chk("zero T+1 in_ready", 32'(rdy[1]), 32'h1);

        // Out-of-range address on a bank of three latches.
        vld[2] = 1'b1; ad[2] = 2'd1; dt[2] = 8'h42;
        tick();
        vld[2] = 1'b0;
        repeat (5) tick();
        vld[2] = 1'b1; ad[2] = 2'd3; dt[2] = 8'hFF;
        tick();
        vld[2] = 1'b0;
        chk("inv err", 32'(er[2]), 32'h1);
        chk("inv lat_en", 32'(en2), 32'h0);
        chk("inv lat_d kept", 32'(ld[2]), 32'h42);
        chk("inv in_ready", 32'(rdy[2]), 32'h1);
        tick();
        chk("inv err one cycle", 32'(er[2]), 32'h0);

        // Reset during the first strobe cycle aborts the write.
        vld[0] = 1'b1; ad[0] = 2'd1; dt[0] = 8'h77;
        tick();
        vld[0] = 1'b0;
        tick();
        chk("pre-abort lat_en", 32'(en0), 32'h2);
        rst = 1'b0;
        tick();
        chk("abort lat_en", 32'(en0), 32'h0);
        chk("abort lat_d", 32'(ld[0]), 32'h00);
        chk("abort busy", 32'(bsy[0]), 32'h0);
        chk("abort in_ready", 32'(rdy[0]), 32'h0);
        rst = 1'b1;
        tick();
        chk("resume in_ready", 32'(rdy[0]), 32'h1);
        chk("resume busy", 32'(bsy[0]), 32'h0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
